// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller and its memory FSM.
package pipe_ctrl_pkg;

  typedef logic [5:0] stall_t;

  // Stall bus bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb; 1 = hold stage.
  localparam stall_t STALL_NONE = 6'b000000;
  localparam stall_t STALL_ID   = 6'b000111;
  localparam stall_t STALL_EX   = 6'b001111;
  localparam stall_t STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    MCTL_IDLE  = 2'd0,
    MCTL_WAIT  = 2'd1,
    MCTL_DONE  = 2'd2,
    MCTL_DRAIN = 2'd3
  } mctl_state_t;

  // Fixed-priority stall arbitration: flush > MEM > EX > ID.
  function automatic stall_t stall_select(input logic flush, input logic req_mem,
                                          input logic req_ex, input logic req_id);
    if (flush)        return STALL_NONE;
    else if (req_mem) return STALL_MEM;
    else if (req_ex)  return STALL_EX;
    else if (req_id)  return STALL_ID;
    else              return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_mem_fsm.sv
// MEM-stage data-memory handshake: zero-wait or waited access, timeout,
// and draining of the ack that belongs to an abandoned access.
module pipe_mem_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic mem_req,
  input  logic mem_ack,
  input  logic excp_valid,
  output logic stallreq_mem,
  output logic dmem_en,
  output logic timeout
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);

  mctl_state_t   state_reg, state_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;

  // State and wait counter registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg    <= MCTL_IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    stallreq_mem  = 1'b0;
    dmem_en       = 1'b0;
    timeout       = 1'b0;
    case (state_reg)
      MCTL_IDLE: begin
        // A flushed load/store must never reach the memory.
        dmem_en      = mem_req & ~excp_valid;
        stallreq_mem = mem_req & ~mem_ack;
        if (!excp_valid && mem_req) begin
          if (mem_ack) begin
            state_next = MCTL_DONE;
          end else begin
            state_next    = MCTL_WAIT;
            wait_cnt_next = '0;
          end
        end
      end
      MCTL_WAIT: begin
        dmem_en       = 1'b1;
        stallreq_mem  = ~mem_ack;
        wait_cnt_next = wait_cnt_reg + 1'b1;
        timeout       = (wait_cnt_reg == LAST_WAIT) & ~mem_ack;
        if (mem_ack) begin
          // An ack arriving with an exception is consumed here, so nothing is left to drain.
          state_next = excp_valid ? MCTL_IDLE : MCTL_DONE;
        end else if (excp_valid || timeout) begin
          state_next    = MCTL_DRAIN;
          wait_cnt_next = '0;
        end
      end
      MCTL_DONE: begin
        // One dead cycle so a still-high mem_req of the retiring op is not restarted.
        state_next = MCTL_IDLE;
      end
      MCTL_DRAIN: begin
        // Hold any new access until the stale ack has been swallowed.
        stallreq_mem = mem_req;
        if (mem_ack) state_next = MCTL_IDLE;
      end
      default: state_next = MCTL_IDLE;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller top: stall arbitration, flush/redirect and stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          MEM_TIMEOUT = 16,
  parameter logic [31:0] BUS_ERR_VEC = 32'h00000040
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        excp_valid,
  input  logic [31:0] excp_vector,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        dmem_en,
  output logic        bus_err,
  output logic [31:0] stall_cycles
);

  logic        stallreq_mem;
  logic        timeout;
  logic [31:0] stall_cycles_reg;

  pipe_mem_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_fsm (
    .clk          (clk),
    .clr          (clr),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .excp_valid   (excp_valid),
    .stallreq_mem (stallreq_mem),
    .dmem_en      (dmem_en),
    .timeout      (timeout)
  );

  // Flush, redirect target and stall selection; an exception vector beats the bus-error vector.
  always_comb begin
    flush   = excp_valid | timeout;
    bus_err = timeout;
    new_pc  = 32'h0;
    if (excp_valid)   new_pc = excp_vector;
    else if (timeout) new_pc = BUS_ERR_VEC;
    stall = stall_select(flush, stallreq_mem, stallreq_ex, stallreq_id);
  end

  // Saturating count of cycles in which any stage is held.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_cycles_reg <= '0;
    end else if (stall != STALL_NONE && stall_cycles_reg != 32'hFFFFFFFF) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: ID/EX stalls, waited memory access,
// timeout with drain, exception during WAIT, and reset mid-access.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        stallreq_id, stallreq_ex, mem_req, mem_ack, excp_valid;
  logic [31:0] excp_vector;
  logic [5:0]  stall;
  logic        flush, dmem_en, bus_err;
  logic [31:0] new_pc, stall_cycles;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] exp_sc;

  pipe_ctrl #(
    .MEM_TIMEOUT (16),
    .BUS_ERR_VEC (32'h00000040)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .excp_valid   (excp_valid),
    .excp_vector  (excp_vector),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .dmem_en      (dmem_en),
    .bus_err      (bus_err),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic id, input logic ex, input logic req, input logic ack,
                       input logic ev, input logic [31:0] vec);
    stallreq_id = id;
    stallreq_ex = ex;
    mem_req     = req;
    mem_ack     = ack;
    excp_valid  = ev;
    excp_vector = vec;
  endtask

  // One cycle: inputs already driven just after a negedge; check, then advance to the next negedge.
  task automatic step(input string tag, input logic [5:0] es, input logic ef,
                      input logic [31:0] enpc, input logic ed, input logic eb);
    #1;
    chk({tag, ":stall"},        {26'b0, stall},   {26'b0, es});
    chk({tag, ":flush"},        {31'b0, flush},   {31'b0, ef});
    chk({tag, ":new_pc"},       new_pc,           enpc);
    chk({tag, ":dmem_en"},      {31'b0, dmem_en}, {31'b0, ed});
    chk({tag, ":bus_err"},      {31'b0, bus_err}, {31'b0, eb});
    chk({tag, ":stall_cycles"}, stall_cycles,     exp_sc);
    $display("%s stall=%b flush=%b new_pc=%h dmem_en=%b bus_err=%b stall_cycles=%0d",
             tag, stall, flush, new_pc, dmem_en, bus_err, stall_cycles);
    if (es != 6'b0) exp_sc = exp_sc + 32'd1;
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b1;
    exp_sc = 32'd0;
    drive(0, 0, 0, 0, 0, 32'h0);
    #2;
    chk("reset:stall",        {26'b0, stall},   32'h0);
    chk("reset:flush",        {31'b0, flush},   32'h0);
    chk("reset:new_pc",       new_pc,           32'h0);
    chk("reset:dmem_en",      {31'b0, dmem_en}, 32'h0);
    chk("reset:bus_err",      {31'b0, bus_err}, 32'h0);
    chk("reset:stall_cycles", stall_cycles,     32'h0);
    @(negedge clk);
    clr = 1'b0;

    // 1. ID stall for a single cycle.
    drive(1, 0, 0, 0, 0, 32'h0); step("t1_id",   6'b000111, 0, 32'h0, 0, 0);
    drive(0, 0, 0, 0, 0, 32'h0); step("t1_idle", 6'b000000, 0, 32'h0, 0, 0);

    // 2. EX and ID together: EX pattern wins.
    drive(1, 1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) step("t2_ex", 6'b001111, 0, 32'h0, 0, 0);
    drive(0, 0, 0, 0, 0, 32'h0); step("t2_idle", 6'b000000, 0, 32'h0, 0, 0);

    // 3. Access acked after 4 stalled cycles; EX request hidden behind MEM.
    drive(0, 0, 1, 0, 0, 32'h0); step("t3_idle_req", 6'b011111, 0, 32'h0, 1, 0);
    drive(0, 1, 1, 0, 0, 32'h0); step("t3_wait1",    6'b011111, 0, 32'h0, 1, 0);
    step("t3_wait2", 6'b011111, 0, 32'h0, 1, 0);
    drive(0, 0, 1, 0, 0, 32'h0); step("t3_wait3",    6'b011111, 0, 32'h0, 1, 0);
    drive(0, 0, 1, 1, 0, 32'h0); step("t3_ack",      6'b000000, 0, 32'h0, 1, 0);
    drive(0, 0, 1, 0, 0, 32'h0); step("t3_done",     6'b000000, 0, 32'h0, 0, 0);
    // Zero-wait access, then its DONE cycle.
    drive(0, 0, 1, 1, 0, 32'h0); step("t3_zw",       6'b000000, 0, 32'h0, 1, 0);
    drive(0, 0, 1, 0, 0, 32'h0); step("t3_zw_done",  6'b000000, 0, 32'h0, 0, 0);
    drive(0, 0, 0, 0, 0, 32'h0); step("t3_idle",     6'b000000, 0, 32'h0, 0, 0);

    // 4. Timeout: 1 IDLE cycle, 15 WAIT cycles, then the bus error in the 16th WAIT cycle.
    drive(0, 0, 1, 0, 0, 32'h0); step("t4_idle_req", 6'b011111, 0, 32'h0, 1, 0);
    for (int i = 0; i < 15; i++) step("t4_wait", 6'b011111, 0, 32'h0, 1, 0);
    step("t4_timeout", 6'b000000, 1, 32'h40, 1, 1);
    step("t4_drain1",  6'b011111, 0, 32'h0, 0, 0);
    step("t4_drain2",  6'b011111, 0, 32'h0, 0, 0);
    drive(0, 0, 1, 1, 0, 32'h0); step("t4_stale_ack", 6'b011111, 0, 32'h0, 0, 0);
    drive(0, 0, 1, 0, 0, 32'h0); step("t4_new_req",   6'b011111, 0, 32'h0, 1, 0);
    drive(0, 0, 1, 1, 0, 32'h0); step("t4_new_ack",   6'b000000, 0, 32'h0, 1, 0);
    drive(0, 0, 0, 0, 0, 32'h0); step("t4_done",      6'b000000, 0, 32'h0, 0, 0);

    // 5. Exception during WAIT with EX busy: flush overrides all stalls.
    drive(0, 0, 1, 0, 0, 32'h0);  step("t5_idle_req", 6'b011111, 0, 32'h0, 1, 0);
    step("t5_wait", 6'b011111, 0, 32'h0, 1, 0);
    drive(0, 1, 1, 0, 1, 32'h80); step("t5_excp",     6'b000000, 1, 32'h80, 1, 0);
    drive(0, 0, 1, 0, 0, 32'h0);  step("t5_drain1",   6'b011111, 0, 32'h0, 0, 0);
    step("t5_drain2", 6'b011111, 0, 32'h0, 0, 0);
    drive(0, 0, 1, 1, 0, 32'h0);  step("t5_stale",    6'b011111, 0, 32'h0, 0, 0);
    step("t5_zw", 6'b000000, 0, 32'h0, 1, 0);
    drive(0, 0, 0, 0, 0, 32'h0);  step("t5_done",     6'b000000, 0, 32'h0, 0, 0);

    // 6. Reset asserted mid-WAIT clears everything at once.
    drive(0, 0, 1, 0, 0, 32'h0); step("t6_idle_req", 6'b011111, 0, 32'h0, 1, 0);
    step("t6_wait", 6'b011111, 0, 32'h0, 1, 0);
    clr = 1'b1;
    drive(0, 0, 0, 0, 0, 32'h0);
    exp_sc = 32'd0;
    #1;
    chk("t6_clr:stall",        {26'b0, stall},   32'h0);
    chk("t6_clr:flush",        {31'b0, flush},   32'h0);
    chk("t6_clr:dmem_en",      {31'b0, dmem_en}, 32'h0);
    chk("t6_clr:bus_err",      {31'b0, bus_err}, 32'h0);
    chk("t6_clr:stall_cycles", stall_cycles,     32'h0);
    @(negedge clk);
    clr = 1'b0;
    step("t6_rel", 6'b000000, 0, 32'h0, 0, 0);
    drive(1, 0, 0, 0, 0, 32'h0); step("t6_id",   6'b000111, 0, 32'h0, 0, 0);
    drive(0, 0, 0, 0, 0, 32'h0); step("t6_idle", 6'b000000, 0, 32'h0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
